// File: rtl/fet_segdriver.sv
// -----------------------------------------------------------------------------
// fet_segdriver
// Break-before-make sequencer for a power FET split into NSEG gated segments.
// On an enable request the segment mask is captured, a dead time elapses with
// all gates off, then the captured segments are turned on one at a time in
// ascending index order. Overcurrent latches a fault that forces every gate
// off until it is explicitly cleared.
//
// Ports
//   clk          block clock, rising edge
//   rst_n        asynchronous active-low reset
//   en_i         on request
//   seg_mask_i   segments allowed to turn on (Ron trim), captured at start
//   ocp_i        overcurrent flag
//   flt_clr_i    fault clear request (only meaningful while faulted)
//   gate_o       per-segment gate enables (registered)
//   on_o         all captured segments fully on (registered)
//   fault_o      latched overcurrent fault (registered)
//
// state | meaning
// ------+----------------------------------------------------------------
// OFF   | all gates off, waiting for en_i with a non-empty mask
// DEAD  | break-before-make dead time, gates still off
// RAMP  | turning captured segments on, one every STEP_CYC cycles
// FULL  | every captured segment on, on_o asserted
// FLT   | overcurrent latched, gates off until cleared with en_i low
// -----------------------------------------------------------------------------
module fet_segdriver #(
    parameter int NSEG     = 4,
    parameter int DEAD_CYC = 4,
    parameter int STEP_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [NSEG-1:0] seg_mask_i,
    input  logic            ocp_i,
    input  logic            flt_clr_i,
    output logic [NSEG-1:0] gate_o,
    output logic            on_o,
    output logic            fault_o
);

    localparam int CMAX = (DEAD_CYC > STEP_CYC) ? DEAD_CYC : STEP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    // The counter holds "cycles left minus one", so a phase of N cycles
    // ends on the edge where it reads zero.
    localparam logic [CW-1:0] DEAD_LD = CW'(DEAD_CYC - 1);
    localparam logic [CW-1:0] STEP_LD = CW'(STEP_CYC - 1);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_DEAD = 3'd1,
        S_RAMP = 3'd2,
        S_FULL = 3'd3,
        S_FLT  = 3'd4
    } state_e;

    state_e          state_q;
    logic [NSEG-1:0] mask_q;
    logic [NSEG-1:0] gate_q;
    logic [CW-1:0]   cnt_q;
    logic            on_q;
    logic            fault_q;

    // Captured segments not yet on, and the lowest of them isolated with the
    // two's-complement trick; unmasked bits are never candidates, so they
    // cost no step.
    logic [NSEG-1:0] rem_d;
    logic [NSEG-1:0] next_bit_d;

    assign rem_d      = mask_q & ~gate_q;
    assign next_bit_d = rem_d & (~rem_d + NSEG'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            mask_q  <= '0;
            gate_q  <= '0;
            cnt_q   <= '0;
            on_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (en_i && (|seg_mask_i)) begin
                        state_q <= S_DEAD;
                        mask_q  <= seg_mask_i;
                        cnt_q   <= DEAD_LD;
                    end
                end

                S_DEAD, S_RAMP, S_FULL: begin
                    if (ocp_i) begin
                        // Overcurrent wins over a simultaneous en_i drop.
                        state_q <= S_FLT;
                        mask_q  <= '0;
                        gate_q  <= '0;
                        cnt_q   <= '0;
                        on_q    <= 1'b0;
                        fault_q <= 1'b1;
                    end else if (!en_i) begin
                        state_q <= S_OFF;
                        mask_q  <= '0;
                        gate_q  <= '0;
                        cnt_q   <= '0;
                        on_q    <= 1'b0;
                    end else if (state_q == S_DEAD) begin
                        if (cnt_q == '0) begin
                            state_q <= S_RAMP;
                            gate_q  <= gate_q | next_bit_d;
                            cnt_q   <= STEP_LD;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end else if (state_q == S_RAMP) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (|rem_d) begin
                            gate_q <= gate_q | next_bit_d;
                            cnt_q  <= STEP_LD;
                        end else begin
                            // Last segment has had its full step to settle.
                            state_q <= S_FULL;
                            cnt_q   <= '0;
                            on_q    <= 1'b1;
                        end
                    end
                end

                S_FLT: begin
                    if (flt_clr_i && !en_i && !ocp_i) begin
                        state_q <= S_OFF;
                        fault_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_OFF;
                    mask_q  <= '0;
                    gate_q  <= '0;
                    cnt_q   <= '0;
                    on_q    <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign gate_o  = gate_q;
    assign on_o    = on_q;
    assign fault_o = fault_q;

endmodule

// File: tb/tb_fet_segdriver.sv
// -----------------------------------------------------------------------------
// tb_fet_segdriver
// Bench for fet_segdriver with NSEG=4, DEAD_CYC=2, STEP_CYC=3. Stimulus comes
// from tables of per-edge vectors; each vector's expected outputs are queued
// when its inputs are driven and compared after the edge that samples them.
// Ramp expectations come from the edge timing formula (k-th captured bit on at
// DEAD+k*STEP, ON at DEAD+m*STEP, edge 0 being the EN sample).
// -----------------------------------------------------------------------------
module tb_fet_segdriver;

    localparam int NSEG = 4;
    localparam int DEAD = 2;
    localparam int STEP = 3;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic       ocp;
        logic       clr;
        logic [3:0] gate;
        logic       on;
        logic       fault;
        string      name;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en_i = 1'b0;
    logic [NSEG-1:0] seg_mask_i = '0;
    logic            ocp_i = 1'b0;
    logic            flt_clr_i = 1'b0;
    logic [NSEG-1:0] gate_o;
    logic            on_o;
    logic            fault_o;

    int checks = 0;
    int failures = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    fet_segdriver #(
        .NSEG     (NSEG),
        .DEAD_CYC (DEAD),
        .STEP_CYC (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .seg_mask_i (seg_mask_i),
        .ocp_i      (ocp_i),
        .flt_clr_i  (flt_clr_i),
        .gate_o     (gate_o),
        .on_o       (on_o),
        .fault_o    (fault_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ramp_gate(input logic [3:0] m, input int e);
        int k;
        logic [3:0] g;
        k = 0;
        g = '0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                if (e >= DEAD + k * STEP) g[i] = 1'b1;
                k++;
            end
        end
        return g;
    endfunction

    function automatic logic ramp_on(input logic [3:0] m, input int e);
        int pc;
        pc = 0;
        for (int i = 0; i < 4; i++) if (m[i]) pc++;
        return (e >= DEAD + pc * STEP);
    endfunction

    task automatic add(input logic en, input logic [3:0] mask, input logic ocp,
                       input logic clr, input logic [3:0] gate, input logic on,
                       input logic fault, input string name);
        vec_t v;
        v.en = en; v.mask = mask; v.ocp = ocp; v.clr = clr;
        v.gate = gate; v.on = on; v.fault = fault; v.name = name;
        tbl.push_back(v);
    endtask

    // Ramp of captured mask m for edges e0..e1 with en held high; the mask
    // input is disturbed after edge 0 to show it is ignored once captured.
    task automatic add_ramp(input logic [3:0] m, input int e0, input int e1,
                            input string name);
        for (int e = e0; e <= e1; e++)
            add(1'b1, (e == 0) ? m : ~m, 1'b0, 1'b0,
                ramp_gate(m, e), ramp_on(m, e), 1'b0, name);
    endtask

    task automatic check_out();
        vec_t x;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: queue empty, got nothing to compare");
            return;
        end
        x = exp_q.pop_front();
        checks++;
        if ({gate_o, on_o, fault_o} !== {x.gate, x.on, x.fault}) begin
            failures++;
            $display("FAIL %s @%0t: got gate=%b on=%b fault=%b, want gate=%b on=%b fault=%b",
                     x.name, $time, gate_o, on_o, fault_o, x.gate, x.on, x.fault);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            en_i       = tbl[i].en;
            seg_mask_i = tbl[i].mask;
            ocp_i      = tbl[i].ocp;
            flt_clr_i  = tbl[i].clr;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            check_out();
        end
        tbl.delete();
    endtask

    // Assert reset between edges and check outputs clear with no clock edge,
    // then release it just after an edge.
    task automatic async_rst(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gate_o, on_o, fault_o} !== 6'b0) begin
            failures++;
            $display("FAIL %s: got gate=%b on=%b fault=%b, want all 0 without edge",
                     name, gate_o, on_o, fault_o);
        end
        en_i = 1'b0; ocp_i = 1'b0; flt_clr_i = 1'b0; seg_mask_i = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        checks++;
        if ({gate_o, on_o, fault_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset: got gate=%b on=%b fault=%b, want all 0",
                     gate_o, on_o, fault_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full mask ramp, with a stray fault clear mid-ramp.
        add_ramp(4'hF, 0, 2, "ramp1111");
        add(1, 4'h0, 0, 1, 4'b0001, 0, 0, "clr_in_ramp");
        add_ramp(4'hF, 4, 15, "ramp1111");
        add(0, 4'hF, 0, 0, 4'h0, 0, 0, "en_drop_full");
        // Sparse mask: unmasked bits are skipped without a step.
        add_ramp(4'hA, 0, 10, "ramp1010");
        add(0, 4'hA, 0, 0, 4'h0, 0, 0, "en_drop_1010");
        // Empty mask never leaves OFF.
        for (int i = 0; i < 3; i++) add(1, 4'h0, 0, 0, 4'h0, 0, 0, "mask_zero");
        // OCP ignored in OFF, acted on in DEAD, then cleared.
        add(0, 4'hF, 1, 0, 4'h0, 0, 0, "ocp_in_off");
        add(1, 4'hF, 1, 0, 4'h0, 0, 0, "ocp_off_to_dead");
        add(1, 4'hF, 1, 0, 4'h0, 0, 1, "ocp_in_dead");
        add(0, 4'h0, 0, 1, 4'h0, 0, 0, "clr_from_dead_flt");
        run_tbl();

        // EN drop mid-ramp, then restart with a fresh dead time.
        add_ramp(4'hF, 0, 5, "abort_ramp");
        for (int e = 6; e <= 8; e++) add(0, 4'hF, 0, 0, 4'h0, 0, 0, "abort_off");
        for (int e = 9; e <= 12; e++)
            add(1, 4'hF, 0, 0, ramp_gate(4'hF, e - 9), 0, 0, "restart");
        add(0, 4'hF, 0, 0, 4'h0, 0, 0, "restart_off");
        run_tbl();

        // Fault from FULL with simultaneous EN drop, then the clear rules.
        add_ramp(4'hF, 0, 14, "to_full");
        add(0, 4'hF, 1, 0, 4'h0, 0, 1, "ocp_beats_en0");
        add(1, 4'hF, 0, 0, 4'h0, 0, 1, "flt_ignores_en");
        add(1, 4'hF, 0, 0, 4'h0, 0, 1, "flt_ignores_en");
        add(1, 4'hF, 0, 1, 4'h0, 0, 1, "clr_with_en");
        add(0, 4'hF, 1, 1, 4'h0, 0, 1, "clr_with_ocp");
        add(0, 4'hF, 0, 1, 4'h0, 0, 0, "clr_ok");
        add_ramp(4'h4, 0, 5, "after_clr");
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, "after_clr_off");
        // Ramp to 0011 for the async reset check.
        add_ramp(4'hF, 0, 5, "pre_reset");
        run_tbl();

        async_rst("rst_mid_ramp");
        for (int i = 0; i < 3; i++) add(1, 4'h0, 0, 0, 4'h0, 0, 0, "post_rst_mask0");
        add_ramp(4'hF, 0, 3, "post_rst_ramp");
        add(1, 4'hF, 1, 0, 4'h0, 0, 1, "ocp_in_ramp");
        run_tbl();

        async_rst("rst_in_flt");
        add_ramp(4'h8, 0, 2, "post_flt_rst");
        add(0, 4'h0, 0, 0, 4'h0, 0, 0, "final_off");
        run_tbl();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
